fetch_sequencer: RTL and testbench

Drives the instruction register's byte-load interface. It reads two consecutive bytes from 8-bit instruction memory, high byte first, and steps its own program counter after each byte. It writes each byte into the 16-bit instruction register half by half, then presents the assembled instruction to the decoder with a valid/ready handshake. It sits between instruction memory and the IR/decoder and also accepts jump redirects from the execute stage.

---
 rtl/fetch_sequencer_pkg.sv | 24 ++
 rtl/fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_fetch_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared cpu types: register FunSel codes, IR half select, fetch states
package fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      FUNSEL_DEC   = 2'd0,
      FUNSEL_INC   = 2'd1,
      FUNSEL_LOAD  = 2'd2,
      FUNSEL_CLEAR = 2'd3
   } funsel_e;

   localparam logic IR_HI = 1'b1;
   localparam logic IR_LO = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ_HI,
      ST_WAIT_HI,
      ST_REQ_LO,
      ST_WAIT_LO,
      ST_ISSUE,
      ST_DRAIN
   } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - two-byte instruction fetch into the IR with decoder handshake and jump redirect
module fetch_sequencer #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_rvalid,
   output logic              ir_en,
   output logic              ir_lh,
   output logic [1:0]        ir_funsel,
   output logic [7:0]        ir_data,
   output logic              inst_valid,
   output logic [15:0]       inst,
   input  logic              inst_ready,
   input  logic              jmp_valid,
   input  logic [ADDR_W-1:0] jmp_addr,
   output logic [ADDR_W-1:0] pc
);
   import fetch_sequencer_pkg::*;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       inst_q, inst_d;
   logic              mem_req_q, mem_req_d;
   logic              ir_en_q, ir_en_d;
   logic              ir_lh_q, ir_lh_d;
   logic [7:0]        ir_data_q, ir_data_d;
   logic              inst_valid_q, inst_valid_d;

   // Next-state logic; a jump overrides every other event, and registered outputs follow the next state
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      ir_en_d   = 1'b0;
      ir_lh_d   = ir_lh_q;
      ir_data_d = ir_data_q;

      if (jmp_valid) begin
         pc_d = jmp_addr;
         unique case (state_q)
            // read issued this cycle is still in flight
            ST_REQ_HI, ST_REQ_LO:             state_d = ST_DRAIN;
            // a response arriving with the jump is simply dropped
            ST_WAIT_HI, ST_WAIT_LO, ST_DRAIN: state_d = mem_rvalid ? ST_REQ_HI : ST_DRAIN;
            default:                          state_d = run ? ST_REQ_HI : ST_IDLE;
         endcase
      end else begin
         unique case (state_q)
            ST_IDLE:   if (run) state_d = ST_REQ_HI;
            ST_REQ_HI: state_d = ST_WAIT_HI;
            ST_REQ_LO: state_d = ST_WAIT_LO;
            ST_WAIT_HI: begin
               if (mem_rvalid) begin
                  inst_d[15:8] = mem_rdata;
                  pc_d         = pc_q + ADDR_W'(1);
                  ir_en_d      = 1'b1;
                  ir_lh_d      = IR_HI;
                  ir_data_d    = mem_rdata;
                  state_d      = ST_REQ_LO;
               end
            end
            ST_WAIT_LO: begin
               if (mem_rvalid) begin
                  inst_d[7:0] = mem_rdata;
                  pc_d        = pc_q + ADDR_W'(1);
                  ir_en_d     = 1'b1;
                  ir_lh_d     = IR_LO;
                  ir_data_d   = mem_rdata;
                  state_d     = ST_ISSUE;
               end
            end
            ST_ISSUE:  if (inst_ready) state_d = run ? ST_REQ_HI : ST_IDLE;
            ST_DRAIN:  if (mem_rvalid) state_d = ST_REQ_HI;
            default:   state_d = ST_IDLE;
         endcase
      end

      mem_req_d    = (state_d == ST_REQ_HI) || (state_d == ST_REQ_LO);
      inst_valid_d = (state_d == ST_ISSUE);
   end

   // State, PC and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         mem_req_q    <= 1'b0;
         ir_en_q      <= 1'b0;
         ir_lh_q      <= 1'b0;
         ir_data_q    <= '0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         mem_req_q    <= mem_req_d;
         ir_en_q      <= ir_en_d;
         ir_lh_q      <= ir_lh_d;
         ir_data_q    <= ir_data_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   // mem_addr is the PC itself: in REQ_* the PC always names the byte being requested
   assign mem_req    = mem_req_q;
   assign mem_addr   = pc_q;
   assign ir_en      = ir_en_q;
   assign ir_lh      = ir_lh_q;
   assign ir_funsel  = FUNSEL_LOAD;
   assign ir_data    = ir_data_q;
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - bench for fetch_sequencer: memory model, transaction-level reference, directed and random stimulus
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_rdata;
   logic        mem_rvalid;
   logic        ir_en;
   logic        ir_lh;
   logic [1:0]  ir_funsel;
   logic [7:0]  ir_data;
   logic        inst_valid;
   logic [15:0] inst;
   logic        inst_ready;
   logic        jmp_valid;
   logic [7:0]  jmp_addr;
   logic [7:0]  pc;

   fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h10)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .ir_en(ir_en), .ir_lh(ir_lh), .ir_funsel(ir_funsel), .ir_data(ir_data),
      .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
      .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .pc(pc)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   int checks = 0;
   int failures = 0;

   // stimulus requested by the test sequence for the coming cycle
   logic       run_i, ready_i, jmp_i;
   logic [7:0] jaddr_i;
   int         lat_i;

   // memory model
   logic [7:0] mem [256];
   bit         busy;
   bit         discard;
   int         due;
   logic [7:0] rdata_r;

   // reference model of the fetch stream
   logic [7:0]  m_pc;
   int          m_byte;
   logic [7:0]  m_hi;
   logic [15:0] m_inst;
   bit          m_pend;
   bit          exp_ir, exp_valid, exp_drop;
   logic        exp_lh;
   logic [7:0]  exp_data;
   logic        prev_req;
   int          cyc;
   int          idle_cnt;

   // observation logs
   int          req_cyc[$];
   logic [7:0]  req_addr[$];
   logic [8:0]  ir_val[$];
   logic [15:0] dlv_log[$];
   int          valid_cyc;
   logic [15:0] valid_inst;
   logic [7:0]  valid_pc;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_logs();
      req_cyc.delete();
      req_addr.delete();
      ir_val.delete();
      dlv_log.delete();
      valid_cyc = -1;
   endtask

   // one clock cycle: check outputs, drive inputs and memory, advance the reference model
   task automatic step();
      logic       rv, rv_disc;
      logic [7:0] rd;

      chk("ir_en", ir_en, exp_ir);
      if (exp_ir) begin
         chk("ir_lh", ir_lh, exp_lh);
         chk("ir_data", ir_data, exp_data);
      end
      chk("pc", pc, m_pc);
      chk("ir_funsel", ir_funsel, 2);
      if (exp_valid) chk("inst_valid_rise", inst_valid, 1);
      if (exp_drop) chk("inst_valid_after_jump", inst_valid, 0);
      if (inst_valid) begin
         chk("inst_expected", m_pend, 1);
         chk("inst", inst, m_inst);
         if (valid_cyc < 0) begin
            valid_cyc  = cyc;
            valid_inst = inst;
            valid_pc   = pc;
         end
         if (ready_i) dlv_log.push_back(inst);
      end
      if (mem_req) begin
         chk("mem_addr", mem_addr, m_pc);
         chk("req_while_outstanding", busy, 0);
         chk("req_pulse_width", prev_req, 0);
         chk("req_while_valid", inst_valid, 0);
         req_cyc.push_back(cyc);
         req_addr.push_back(mem_addr);
      end
      if (ir_en) ir_val.push_back({ir_lh, ir_data});
      if (run_i && !busy && !inst_valid && !mem_req) begin
         idle_cnt++;
         if (idle_cnt > 4) begin
            chk("stall_cycles", idle_cnt, 0);
            idle_cnt = 0;
         end
      end else begin
         idle_cnt = 0;
      end

      rv      = busy && (cyc == due);
      rv_disc = rv && discard;
      rd      = rdata_r;
      mem_rvalid = rv;
      mem_rdata  = rv ? rd : 8'($urandom);
      run        = run_i;
      inst_ready = ready_i;
      jmp_valid  = jmp_i;
      jmp_addr   = jaddr_i;
      if (rv) busy = 1'b0;
      if (mem_req) begin
         busy    = 1'b1;
         discard = 1'b0;
         due     = cyc + lat_i;
         rdata_r = mem[mem_addr];
      end

      exp_ir    = 1'b0;
      exp_valid = 1'b0;
      exp_drop  = 1'b0;
      if (jmp_i) begin
         m_pc     = jaddr_i;
         m_byte   = 0;
         m_pend   = 1'b0;
         exp_drop = 1'b1;
         if (busy) discard = 1'b1;
      end else begin
         if (rv && !rv_disc) begin
            exp_ir   = 1'b1;
            exp_data = rd;
            exp_lh   = (m_byte == 0);
            m_pc     = m_pc + 8'd1;
            if (m_byte == 0) begin
               m_hi   = rd;
               m_byte = 1;
            end else begin
               m_inst    = {m_hi, rd};
               m_pend    = 1'b1;
               exp_valid = 1'b1;
               m_byte    = 0;
            end
         end
         if (inst_valid && ready_i) m_pend = 1'b0;
      end
      prev_req = mem_req;
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset(int n);
      rst_n      = 1'b0;
      run        = 1'b0;
      inst_ready = 1'b0;
      jmp_valid  = 1'b0;
      jmp_addr   = '0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      run_i = 1'b0; ready_i = 1'b0; jmp_i = 1'b0; jaddr_i = '0; lat_i = 1;
      busy = 1'b0; discard = 1'b0; due = 0;
      m_pc = 8'h10; m_byte = 0; m_pend = 1'b0;
      exp_ir = 1'b0; exp_valid = 1'b0; exp_drop = 1'b0;
      prev_req = 1'b0; idle_cnt = 0;
      repeat (n) @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_ir_en", ir_en, 0);
      chk("rst_ir_lh", ir_lh, 0);
      chk("rst_ir_data", ir_data, 0);
      chk("rst_ir_funsel", ir_funsel, 2);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_pc", pc, 8'h10);
      rst_n = 1'b1;
   endtask

   initial begin
      int c0;
      int jc;
      cyc = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C;
      mem[8'h12] = 8'hC3; mem[8'h13] = 8'h5A;
      mem[8'hFF] = 8'h12; mem[8'h00] = 8'h34;
      mem[8'h40] = 8'h77;

      do_reset(2);

      // first fetch from RESET_PC with single-cycle memory
      run_i = 1'b1; ready_i = 1'b1; lat_i = 1;
      clear_logs();
      c0 = cyc;
      repeat (6) step();
      chk("t1_req_count", req_addr.size(), 2);
      if (req_addr.size() >= 2) begin
         chk("t1_req0_addr", req_addr[0], 8'h10);
         chk("t1_req0_cyc", req_cyc[0] - c0, 1);
         chk("t1_req1_addr", req_addr[1], 8'h11);
         chk("t1_req1_cyc", req_cyc[1] - c0, 3);
      end
      chk("t1_ir_count", ir_val.size(), 2);
      if (ir_val.size() >= 2) begin
         chk("t1_ir_hi", ir_val[0], {1'b1, 8'hA5});
         chk("t1_ir_lo", ir_val[1], {1'b0, 8'h3C});
      end
      chk("t1_valid_cyc", valid_cyc - c0, 5);
      chk("t1_inst", valid_inst, 16'hA53C);
      chk("t1_pc", valid_pc, 8'h12);
      chk("t1_next_req", mem_req, 1);
      chk("t1_next_addr", mem_addr, 8'h12);

      // decoder stalls four cycles
      ready_i = 1'b0;
      for (int k = 0; k < 20 && !inst_valid; k++) step();
      chk("t2_valid", inst_valid, 1);
      for (int k = 0; k < 4; k++) begin
         chk("t2_hold_valid", inst_valid, 1);
         chk("t2_hold_inst", inst, 16'hC35A);
         chk("t2_no_req", mem_req, 0);
         step();
      end
      ready_i = 1'b1;
      step();
      chk("t2_req_after_ready", mem_req, 1);
      chk("t2_req_addr", mem_addr, 8'h14);

      // jump to 0xFF so the next instruction straddles the wrap
      jmp_i = 1'b1; jaddr_i = 8'hFF; lat_i = 2;
      step();
      jmp_i = 1'b0;
      clear_logs();
      for (int k = 0; k < 40 && dlv_log.size() == 0; k++) step();
      chk("t3_delivered", dlv_log.size(), 1);
      if (dlv_log.size() >= 1) chk("t3_inst", dlv_log[0], 16'h1234);
      chk("t3_pc_wrap", valid_pc, 8'h01);
      chk("t3_ir_count", ir_val.size(), 2);
      if (req_addr.size() >= 2) begin
         chk("t3_req_ff", req_addr[0], 8'hFF);
         chk("t3_req_00", req_addr[1], 8'h00);
      end

      // jump while waiting for the high byte, 3-cycle memory
      chk("t4_at_req", mem_req, 1);
      lat_i = 3;
      step();
      jmp_i = 1'b1; jaddr_i = 8'h40; lat_i = 1;
      clear_logs();
      jc = cyc;
      step();
      jmp_i = 1'b0;
      for (int k = 0; k < 20 && !(ir_en && ir_lh); k++) step();
      chk("t4_no_stale_ir", ir_val.size(), 0);
      chk("t4_ir_after_drain", {ir_en, ir_lh, ir_data}, {2'b11, 8'h77});
      if (req_addr.size() >= 1) begin
         chk("t4_req_addr", req_addr[0], 8'h40);
         chk("t4_req_cyc", req_cyc[0] - jc, 3);
      end

      // jump coinciding with the low-byte response
      lat_i = 2;
      step();
      step();
      jmp_i = 1'b1; jaddr_i = 8'h80;
      step();
      jmp_i = 1'b0; lat_i = 1;
      chk("t5_no_ir_en", ir_en, 0);
      chk("t5_req", mem_req, 1);
      chk("t5_req_addr", mem_addr, 8'h80);

      // reset while waiting for the low byte
      step();
      step();
      chk("t6_at_req_lo", {mem_req, ir_en, ir_lh}, 3'b111);
      lat_i = 3;
      step();
      do_reset(1);
      run_i = 1'b0; ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("t6_idle_no_req", mem_req, 0);
         step();
      end

      // randomized traffic against the reference model
      clear_logs();
      for (int k = 0; k < 4000; k++) begin
         run_i   = ($urandom_range(0, 7) != 0);
         ready_i = ($urandom_range(0, 2) != 0);
         jmp_i   = ($urandom_range(0, 24) == 0);
         jaddr_i = 8'($urandom);
         lat_i   = $urandom_range(1, 4);
         step();
      end
      chk("rand_progress", dlv_log.size() > 50, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
